ue14500_sys_responder: RTL and testbench

System-side companion to the UE14500 1-bit core: the program counter, instruction fetch and addressable I/O that the core's control outputs drive. Each cycle it presents the current program word, splits it into a 4-bit opcode for the core and a 4-bit I/O address, and routes the addressed input bit to the core. It acts on the core's WRITE, JMP, RTN, FLAG0 and FLAGF strobes. It sits between the core and the program/IO pins inside the tile's top module.

---
 rtl/ue14500_pkg.sv | 38 +++
 rtl/ue14500_io_port.sv | 51 +++++
 rtl/ue14500_sys_responder.sv | 117 +++++++++++
 tb/tb_ue14500_sys_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ue14500_pkg.sv
// ue14500_pkg
// Shared definitions for the UE14500 core and its system-side responder:
//   - state_t    : responder sequencing states (IDLE / RUN / HALT)
//   - OP_*       : 4-bit opcode encodings carried in the program word
//   - OPC_*/ADDR_*: bit positions of the opcode and I/O address fields
//                   inside the 8-bit program word
package ue14500_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [3:0] OP_NOP0 = 4'h0;
   localparam logic [3:0] OP_LD   = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_ONE  = 4'h4;
   localparam logic [3:0] OP_NAND = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_STO  = 4'h8;
   localparam logic [3:0] OP_STOC = 4'h9;
   localparam logic [3:0] OP_IEN  = 4'hA;
   localparam logic [3:0] OP_OEN  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_RTN  = 4'hD;
   localparam logic [3:0] OP_SKZ  = 4'hE;
   localparam logic [3:0] OP_NOPF = 4'hF;

   // Program word layout: [OPC_MSB:OPC_LSB] opcode, [ADDR_MSB:ADDR_LSB] I/O address
   localparam int unsigned OPC_MSB  = 7;
   localparam int unsigned OPC_LSB  = 4;
   localparam int unsigned ADDR_MSB = 3;
   localparam int unsigned ADDR_LSB = 0;

endpackage : ue14500_pkg

// File: rtl/ue14500_io_port.sv
// ue14500_io_port
// Addressable I/O for the UE14500 responder.
//   clk, rst_n : clock, asynchronous active-low reset (clears the latch)
//   wr_en      : write strobe, already qualified with the RUN state
//   addr[3:0]  : I/O address; 0-7 select inputs/latch bits, 8-15 read back the latch
//   wr_data    : bit written into ext_out[addr[2:0]] when addr[3]=0
//   ext_in     : external input bits
//   ext_out    : 8-bit output latch
//   rd_data    : combinational read of the addressed bit
module ue14500_io_port (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [3:0] addr,
   input  logic       wr_data,
   input  logic [7:0] ext_in,
   output logic [7:0] ext_out,
   output logic       rd_data
);

   logic [7:0] ext_out_q;
   logic [7:0] ext_out_d;

   // Upper half of the address space is read-only latch read-back
   always_comb begin
      ext_out_d = ext_out_q;
      if (wr_en && !addr[3]) begin
         ext_out_d[addr[2:0]] = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_out_q <= '0;
      end else begin
         ext_out_q <= ext_out_d;
      end
   end

   always_comb begin
      rd_data = 1'b0;
      if (addr[3]) begin
         rd_data = ext_out_q[addr[2:0]];
      end else begin
         rd_data = ext_in[addr[2:0]];
      end
   end

   assign ext_out = ext_out_q;

endmodule : ue14500_io_port

// File: rtl/ue14500_sys_responder.sv
// ue14500_sys_responder
// System side of the UE14500 1-bit core: program counter, fetch and I/O routing.
//   PC_W          : program counter width (2^PC_W program words)
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : level; leaves IDLE/HALT and runs from address 0
//   mem_addr      : registered program address
//   mem_data      : program word (opcode | I/O address), valid same cycle
//   core_instr    : opcode to the core, NOP0 outside RUN
//   core_data_in  : addressed input bit to the core
//   core_data_out : data bit from the core for writes
//   core_write/jmp/rtn/flag0/flagf : core strobes for the presented word
//   ext_in/ext_out: external inputs / addressable output latch
//   flag0_pulse   : registered echo of core_flag0 while running
//   halted/running: decoded from the registered state
module ue14500_sys_responder
   import ue14500_pkg::*;
#(
   parameter int unsigned PC_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [PC_W-1:0] mem_addr,
   input  logic [7:0]      mem_data,
   output logic [3:0]      core_instr,
   output logic            core_data_in,
   input  logic            core_data_out,
   input  logic            core_write,
   input  logic            core_jmp,
   input  logic            core_rtn,
   input  logic            core_flag0,
   input  logic            core_flagf,
   input  logic [7:0]      ext_in,
   output logic [7:0]      ext_out,
   output logic            flag0_pulse,
   output logic            halted,
   output logic            running
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            flag0_pulse_q, flag0_pulse_d;
   logic [3:0]      io_addr;
   logic [PC_W-1:0] jmp_target;
   logic            wr_en;

   assign io_addr    = mem_data[ADDR_MSB:ADDR_LSB];
   // Zero-extends or truncates the 4-bit field to the PC width
   assign jmp_target = PC_W'(io_addr);
   assign wr_en      = core_write && (state_q == ST_RUN);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      flag0_pulse_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pc_d = '0;
            if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            flag0_pulse_d = core_flag0;
            if (core_flagf) begin
               state_d = ST_HALT;
            end else if (core_jmp) begin
               pc_d = jmp_target;
            end else if (core_rtn) begin
               pc_d = pc_q + PC_W'(2);
            end else begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         ST_HALT: begin
            if (start) begin
               pc_d    = '0;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            pc_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= '0;
         flag0_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         flag0_pulse_q <= flag0_pulse_d;
      end
   end

   ue14500_io_port u_io_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .addr    (io_addr),
      .wr_data (core_data_out),
      .ext_in  (ext_in),
      .ext_out (ext_out),
      .rd_data (core_data_in)
   );

   assign core_instr  = (state_q == ST_RUN) ? mem_data[OPC_MSB:OPC_LSB] : OP_NOP0;
   assign mem_addr    = pc_q;
   assign flag0_pulse = flag0_pulse_q;
   assign halted      = (state_q == ST_HALT);
   assign running     = (state_q == ST_RUN);

endmodule : ue14500_sys_responder

// File: tb/tb_ue14500_sys_responder.sv
module tb_ue14500_sys_responder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] mem_addr;
   logic [7:0] mem_data;
   logic [3:0] core_instr;
   logic       core_data_in;
   logic       core_data_out;
   logic       core_write, core_jmp, core_rtn, core_flag0, core_flagf;
   logic [7:0] ext_in;
   logic [7:0] ext_out;
   logic       flag0_pulse, halted, running;

   logic [7:0] prog [16];
   logic       use_ovr;
   logic [7:0] ovr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mem_data = use_ovr ? ovr : prog[mem_addr];

   ue14500_sys_responder #(.PC_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .core_instr    (core_instr),
      .core_data_in  (core_data_in),
      .core_data_out (core_data_out),
      .core_write    (core_write),
      .core_jmp      (core_jmp),
      .core_rtn      (core_rtn),
      .core_flag0    (core_flag0),
      .core_flagf    (core_flagf),
      .ext_in        (ext_in),
      .ext_out       (ext_out),
      .flag0_pulse   (flag0_pulse),
      .halted        (halted),
      .running       (running)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_bit(input logic [2:0] a, input logic v);
      ovr           = {4'h8, 1'b0, a};
      core_write    = 1'b1;
      core_data_out = v;
      step();
      core_write    = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) prog[i] = 8'h10;
      prog[0] = 8'h83;
      prog[1] = 8'h1B;
      prog[2] = 8'h2C;
      prog[3] = 8'h35;
      prog[5] = 8'hC2;
      prog[6] = 8'h64;
      use_ovr = 1'b0; ovr = 8'h00;
      rst_n = 1'b0; start = 1'b0; core_data_out = 1'b0;
      core_write = 1'b0; core_jmp = 1'b0; core_rtn = 1'b0;
      core_flag0 = 1'b0; core_flagf = 1'b0; ext_in = 8'h00;

      // Reset values
      step();
      check("rst_mem_addr", mem_addr, 4'h0);
      check("rst_ext_out", ext_out, 8'h00);
      check("rst_running", running, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_flag0_pulse", flag0_pulse, 1'b0);
      rst_n = 1'b1;
      step();

      // Start, then straight-line run with wrap
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_running", running, 1'b1);
      check("start_mem_addr", mem_addr, 4'h0);
      #1 check("run_core_instr", core_instr, 4'h8);
      for (int i = 1; i <= 16; i++) begin
         step();
         check($sformatf("seq_pc_%0d", i), mem_addr, 32'(i % 16));
      end

      // Write word 0x83 at PC0 -> ext_out bit 3
      core_write = 1'b1; core_data_out = 1'b1;
      step();
      core_write = 1'b0; core_data_out = 1'b0;
      check("wr_ext_out", ext_out, 8'h08);
      check("wr_pc", mem_addr, 4'h1);
      #1 check("rd_latch_0xB", core_data_in, 1'b1);
      step();
      check("pc2", mem_addr, 4'h2);
      core_write = 1'b1; core_data_out = 1'b1;
      step();
      core_write = 1'b0; core_data_out = 1'b0;
      check("wr_0xC_ignored", ext_out, 8'h08);
      ext_in = 8'h20;
      #1 check("rd_ext_in_5_hi", core_data_in, 1'b1);
      ext_in = 8'hDF;
      #1 check("rd_ext_in_5_lo", core_data_in, 1'b0);
      ext_in = 8'h00;

      // Jump at PC5 to 2
      step(); step();
      check("pc5", mem_addr, 4'h5);
      core_jmp = 1'b1;
      step();
      core_jmp = 1'b0;
      check("jmp_target", mem_addr, 4'h2);
      for (int i = 0; i < 5; i++) step();
      check("pc7", mem_addr, 4'h7);
      core_rtn = 1'b1;
      step();
      core_rtn = 1'b0;
      check("rtn_skip", mem_addr, 4'h9);
      for (int i = 0; i < 6; i++) step();
      check("pc15", mem_addr, 4'hF);
      core_rtn = 1'b1;
      step();
      core_rtn = 1'b0;
      check("rtn_wrap", mem_addr, 4'h1);

      // flagf + jmp + write together at PC6
      for (int i = 0; i < 5; i++) step();
      check("pc6", mem_addr, 4'h6);
      core_flagf = 1'b1; core_jmp = 1'b1; core_write = 1'b1; core_data_out = 1'b1;
      step();
      check("halt_halted", halted, 1'b1);
      check("halt_running", running, 1'b0);
      check("halt_mem_addr", mem_addr, 4'h6);
      check("halt_core_instr", core_instr, 4'h0);
      check("halt_write_same_cycle", ext_out, 8'h18);
      core_data_out = 1'b0;
      step();
      check("halt_frozen_pc", mem_addr, 4'h6);
      check("halt_no_write", ext_out, 8'h18);
      core_flagf = 1'b0; core_jmp = 1'b0; core_write = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_mem_addr", mem_addr, 4'h0);
      check("restart_running", running, 1'b1);
      check("restart_halted", halted, 1'b0);

      // flag0 echo
      core_flag0 = 1'b1;
      step();
      core_flag0 = 1'b0;
      check("flag0_pulse_hi", flag0_pulse, 1'b1);
      step();
      check("flag0_pulse_lo", flag0_pulse, 1'b0);

      // Build ext_out = A5, then async reset mid-run
      use_ovr = 1'b1;
      write_bit(3'd0, 1'b1);
      write_bit(3'd2, 1'b1);
      write_bit(3'd3, 1'b0);
      write_bit(3'd4, 1'b0);
      write_bit(3'd5, 1'b1);
      write_bit(3'd7, 1'b1);
      use_ovr = 1'b0;
      check("pre_reset_ext_out", ext_out, 8'hA5);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ext_out", ext_out, 8'h00);
      check("async_rst_running", running, 1'b0);
      check("async_rst_mem_addr", mem_addr, 4'h0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("idle_mem_addr_%0d", i), mem_addr, 4'h0);
         check($sformatf("idle_core_instr_%0d", i), core_instr, 4'h0);
         check($sformatf("idle_running_%0d", i), running, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_ue14500_sys_responder
